// File: rtl/btn_debounce.sv
// Push-button debouncer: two-flop synchronizer followed by a stability counter.
// Define BTN_DEBOUNCE_EDGE_EN to add registered one-cycle btn_rise/btn_fall pulses.
module btn_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out
`ifdef BTN_DEBOUNCE_EDGE_EN
  ,
  output logic btn_rise,
  output logic btn_fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             s1_r;
  logic             s2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             out_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             out_nxt_s;

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn_in;
      s2_r <= s1_r;
    end
  end

  // Stability window: any return to the current level restarts the full count
  always_comb begin
    cnt_nxt_s = cnt_r;
    out_nxt_s = out_r;
    if (s2_r == out_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      out_nxt_s = s2_r;
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Counter and debounced level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
      out_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      out_r <= out_nxt_s;
    end
  end

  assign btn_out = out_r;

`ifdef BTN_DEBOUNCE_EDGE_EN
  logic rise_r;
  logic fall_r;

  // Edge pulses register alongside out_r so they coincide with its transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= ~out_r & out_nxt_s;
      fall_r <= out_r & ~out_nxt_s;
    end
  end

  assign btn_rise = rise_r;
  assign btn_fall = fall_r;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (default STABLE_CYCLES = 4).
// Define BTN_DEBOUNCE_EDGE_EN for the edge-pulse checks as well.
module tb_btn_debounce;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_out;
`ifdef BTN_DEBOUNCE_EDGE_EN
  logic btn_rise;
  logic btn_fall;
`endif

  int tests;
  int fails;

  btn_debounce dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_in  (btn_in),
    .btn_out (btn_out)
`ifdef BTN_DEBOUNCE_EDGE_EN
    ,
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
`endif
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ns ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      btn_in = i[0];
      tick();
      tests++;
      if (btn_out !== 1'b0) begin
        fails++;
        $display("FAIL reset_out cycle %0d: got %b expected 0", i, btn_out);
      end
      tests++;
      if (dut.cnt_r !== 2'd0) begin
        fails++;
        $display("FAIL reset_cnt cycle %0d: got %0d expected 0", i, dut.cnt_r);
      end
`ifdef BTN_DEBOUNCE_EDGE_EN
      tests++;
      if (btn_rise !== 1'b0 || btn_fall !== 1'b0) begin
        fails++;
        $display("FAIL reset_edges cycle %0d: got rise=%b fall=%b expected 0 0", i, btn_rise, btn_fall);
      end
`endif
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (btn_out !== 1'b0) begin
      fails++;
      $display("FAIL idle_low: got %b expected 0", btn_out);
    end
  endtask

  // Drive a clean level change and expect btn_out to follow on the 6th edge
  task automatic test_clean(input logic lvl);
    logic exp_out;
    btn_in = lvl;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_out = (e >= 6) ? lvl : ~lvl;
      tests++;
      if (btn_out !== exp_out) begin
        fails++;
        $display("FAIL clean_%0s edge %0d: got %b expected %b", lvl ? "press" : "release", e, btn_out, exp_out);
      end
`ifdef BTN_DEBOUNCE_EDGE_EN
      tests++;
      if (btn_rise !== (lvl && e == 6) || btn_fall !== (!lvl && e == 6)) begin
        fails++;
        $display("FAIL clean_edges edge %0d: got rise=%b fall=%b expected %b %b", e, btn_rise, btn_fall, (lvl && e == 6), (!lvl && e == 6));
      end
`endif
    end
  endtask

  task automatic test_press();
    test_clean(1'b1);
  endtask

  task automatic test_release();
    test_clean(1'b0);
  endtask

  // Bounces land so that edges 1..3 sample 1,0,0; stable high from edge 4 -> rise at edge 9
  task automatic test_bouncy();
    fork
      begin
        #5 btn_in = 1'b1;
        #10 btn_in = 1'b0;
        #5 btn_in = 1'b1;
        #8 btn_in = 1'b0;
        #3 btn_in = 1'b1;
      end
      begin
        logic exp_out;
        for (int e = 1; e <= 15; e++) begin
          tick();
          exp_out = (e >= 9) ? 1'b1 : 1'b0;
          tests++;
          if (btn_out !== exp_out) begin
            fails++;
            $display("FAIL bouncy edge %0d: got %b expected %b", e, btn_out, exp_out);
          end
`ifdef BTN_DEBOUNCE_EDGE_EN
          tests++;
          if (btn_rise !== (e == 9) || btn_fall !== 1'b0) begin
            fails++;
            $display("FAIL bouncy_edges edge %0d: got rise=%b fall=%b expected %b 0", e, btn_rise, btn_fall, (e == 9));
          end
`endif
        end
      end
    join
  endtask

  // Three sampled high cycles count 1,2,3 then clear before reaching terminal count
  task automatic test_glitch();
    logic [1:0] exp_cnt [1:10];
    exp_cnt = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    tests++;
    if (btn_out !== 1'b0) begin
      fails++;
      $display("FAIL glitch_setup: got %b expected 0", btn_out);
    end
    btn_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) btn_in = 1'b0;
      tests++;
      if (btn_out !== 1'b0 || dut.cnt_r !== exp_cnt[e]) begin
        fails++;
        $display("FAIL glitch edge %0d: got out=%b cnt=%0d expected out=0 cnt=%0d", e, btn_out, dut.cnt_r, exp_cnt[e]);
      end
    end
  endtask

  task automatic test_reset_mid();
    btn_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (btn_out !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: got %b expected 1", btn_out);
    end
    btn_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (btn_out !== 1'b1 || dut.cnt_r !== 2'd2) begin
      fails++;
      $display("FAIL mid_counting: got out=%b cnt=%0d expected out=1 cnt=2", btn_out, dut.cnt_r);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (btn_out !== 1'b0 || dut.cnt_r !== 2'd0) begin
      fails++;
      $display("FAIL mid_async_reset: got out=%b cnt=%0d expected out=0 cnt=0", btn_out, dut.cnt_r);
    end
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef BTN_DEBOUNCE_EDGE_EN
      tests++;
      if (btn_fall !== 1'b0 || btn_rise !== 1'b0) begin
        fails++;
        $display("FAIL mid_no_pulse cycle %0d: got rise=%b fall=%b expected 0 0", i, btn_rise, btn_fall);
      end
`endif
      tests++;
      if (btn_out !== 1'b0) begin
        fails++;
        $display("FAIL mid_hold cycle %0d: got %b expected 0", i, btn_out);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      tests++;
      if (btn_out !== (e >= 6)) begin
        fails++;
        $display("FAIL mid_fresh_press edge %0d: got %b expected %b", e, btn_out, (e >= 6));
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    btn_in = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bouncy();
    test_glitch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Debounces one raw, asynchronous push-button input into a clean, glitch-free level (`btn_out`) in the `clk` domain.
- Sits between an FPGA pin and game logic, e.g. fire/move buttons feeding player control and shot logic.
- Structure: two-flop synchronizer, then a stability counter. The output changes only after the synchronized input has held a new level for a programmable number of consecutive cycles.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the synchronized input must differ from `btn_out` before `btn_out` takes the new value.
  - Legal range 2..2^24.
  - Default 4 suits simulation; hardware tops override it (e.g. 1_000_000 = 10 ms at 100 MHz).
- CNT_W, $clog2(STABLE_CYCLES), stability counter width. Derived, not to be overridden; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  1  raw button level; asynchronous, may bounce or glitch at any time, active-high (1 = pressed).
- btn_out  output  1  debounced, registered button level.
- btn_rise  output  1  one-cycle press pulse; present only with BTN_DEBOUNCE_EDGE_EN.
- btn_fall  output  1  one-cycle release pulse; present only with BTN_DEBOUNCE_EDGE_EN.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0, the following are all 0 immediately, independent of clk: synchronizer flops s1 and s2, counter cnt, btn_out, btn_rise, btn_fall.
- Synchronizer: s1 <= btn_in; s2 <= s1. Only s2 is used downstream.
- Counter rule, evaluated each rising edge, in priority order:
  - If s2 == btn_out: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: btn_out <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: btn_out takes a new level on the (STABLE_CYCLES+2)th rising edge, counting the first edge that samples the new btn_in level.
  - With the default 4, that is the 6th edge, i.e. 60 ns at 100 MHz.
- Any return of s2 to the btn_out level before terminal count clears cnt to 0. A bounce restarts the full window; there is no partial credit.
- Pulses shorter than one clock period that no rising edge samples are invisible by construction.
- A sampled glitch lasting fewer than STABLE_CYCLES cycles never reaches btn_out.
- Symmetric: identical rule and latency for press (0->1) and release (1->0).
- btn_out toggles at most once per STABLE_CYCLES cycles. The counter never wraps; it saturates through the terminal-count reset.
- Deassertion of rst_n while btn_in=1: treated as a fresh press, so btn_out rises after the normal latency.
- Assertion of rst_n mid-count: count is discarded, btn_out forced to 0.
- No combinational path from btn_in to any output.

Optional Feature:
- Macro: BTN_DEBOUNCE_EDGE_EN.
- Defined:
  - Ports btn_rise and btn_fall exist, both registered.
  - btn_rise = 1 for exactly one cycle, on the same edge btn_out goes 0->1.
  - btn_fall = 1 for exactly one cycle, on the same edge btn_out goes 1->0.
  - Both are 0 at all other times and during reset, and are never high simultaneously.
- Undefined: these ports and their registers do not exist; btn_out behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with btn_in toggling -> btn_out=0 and cnt=0 throughout; btn_rise and btn_fall stay 0.
- Clean press: after reset, btn_in=0 for 100 ns, then 1 for 100 ns at 100 MHz -> btn_out rises exactly 6 edges after btn_in is first sampled high. With EDGE_EN, btn_rise is high for that single cycle.
- Clean release: btn_in 1->0 held 100 ns -> btn_out falls 6 edges later; btn_fall pulses once.
- Bouncy press: btn_in=1 for 10 ns, 0 for 5 ns, 1 for 8 ns, 0 for 3 ns, then 1 for 100 ns:
  - btn_out has no transition until btn_in has been stably sampled high for 4 cycles after synchronization.
  - It then rises exactly once, with no double pulse.
- Short glitch: btn_in=1 for 3 cycles (30 ns), then 0 -> btn_out stays 0 and cnt returns to 0.
- Reset mid-operation: btn_out=1, btn_in=0 counting toward release; assert rst_n after 2 cycles -> btn_out=0 at once, no btn_fall pulse. Release rst_n with btn_in=1 -> btn_out rises after 6 edges.
